// File: rtl/instruction_sequencer.sv
// Fetch/decode/issue controller for the 8-bit instruction datapath.
// Fetches one instruction per pass from imem at pc, decodes instr[7:6] into
// a one-hot mode and offers it to the execute units over valid/ready.
// All outputs are registered; the strobes are derived from the next state.
module instruction_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [7:0]        imem_rdata,
    output logic [7:0]        instr,
    output logic [3:0]        mode,
    output logic              exec_valid,
    input  logic              exec_ready,
    input  logic              cond_true,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_ERR
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              halt_pend_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [7:0]        instr_reg;
    logic [3:0]        mode_reg;
    logic              rd_en_reg;
    logic              exec_valid_reg;
    logic              busy_reg;
    logic              err_reg;

    logic              rd_en_next;
    logic              exec_valid_next;
    logic              busy_next;
    logic              err_next;

    logic              handshake;
    logic              wait_expired;
    logic              busy_state;

    // The execute unit accepts only while an instruction is being offered.
    assign handshake    = (state_reg == S_ISSUE) && exec_ready;
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign busy_state   = (state_reg != S_IDLE) && (state_reg != S_ERR);

    // State register together with the registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            rd_en_reg      <= 1'b0;
            exec_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_en_reg      <= rd_en_next;
            exec_valid_reg <= exec_valid_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    // Next-state selection; a valid in the final wait cycle beats the timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_WAIT;
            S_WAIT: begin
                if (imem_valid)        state_next = S_DECODE;
                else if (wait_expired) state_next = S_ERR;
            end
            S_DECODE: state_next = S_ISSUE;
            S_ISSUE: begin
                if (handshake) state_next = (halt_pend_reg || halt) ? S_IDLE : S_FETCH;
            end
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control outputs for the coming cycle, registered by the state process
    always_comb begin
        rd_en_next      = (state_next == S_FETCH);
        exec_valid_next = (state_next == S_ISSUE);
        busy_next       = (state_next != S_IDLE) && (state_next != S_ERR);
        err_next        = (state_next == S_ERR);
    end

    // Datapath: wait counter, halt request, instruction/mode latch and pc
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg  <= '0;
            halt_pend_reg <= 1'b0;
            pc_reg        <= '0;
            instr_reg     <= 8'h00;
            mode_reg      <= 4'b0000;
        end else begin
            if (state_reg == S_FETCH)
                wait_cnt_reg <= '0;
            else if (state_reg == S_WAIT && !imem_valid && !wait_expired)
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);

            // A halt is remembered until the sequencer next parks in IDLE
            if (state_next == S_IDLE)
                halt_pend_reg <= 1'b0;
            else if (halt && busy_state)
                halt_pend_reg <= 1'b1;

            if (state_reg == S_WAIT && imem_valid)
                instr_reg <= imem_rdata;

            if (state_reg == S_DECODE)
                mode_reg <= 4'b0001 << instr_reg[7:6];

            if (handshake) begin
                if (mode_reg[3] && cond_true)
                    pc_reg <= jump_target;
                else
                    pc_reg <= pc_reg + ADDR_W'(1);
            end
        end
    end

    assign imem_rd_en = rd_en_reg;
    assign imem_addr  = pc_reg;
    assign instr      = instr_reg;
    assign mode       = mode_reg;
    assign exec_valid = exec_valid_reg;
    assign pc         = pc_reg;
    assign busy       = busy_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: sequential, branch, backpressure,
// pc wrap, halt, fetch timeout and mid-issue reset scenarios.
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       imem_rd_en;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic [3:0] mode;
    logic       exec_valid;
    logic       exec_ready;
    logic       cond_true;
    logic [7:0] jump_target;
    logic [7:0] pc;
    logic       busy;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

    instruction_sequencer #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .mode        (mode),
        .exec_valid  (exec_valid),
        .exec_ready  (exec_ready),
        .cond_true   (cond_true),
        .jump_target (jump_target),
        .pc          (pc),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    32'(pc),         32'(8'h00));
        check({tag, "_addr"},  32'(imem_addr),  32'(8'h00));
        check({tag, "_instr"}, 32'(instr),      32'(8'h00));
        check({tag, "_mode"},  32'(mode),       32'(4'b0000));
        check({tag, "_rd_en"}, 32'(imem_rd_en), 32'(1'b0));
        check({tag, "_evld"},  32'(exec_valid), 32'(1'b0));
        check({tag, "_busy"},  32'(busy),       32'(1'b0));
        check({tag, "_err"},   32'(err),        32'(1'b0));
    endtask

    // Runs one instruction starting in the FETCH cycle
    task automatic issue_instr(input logic [7:0] data, input int wait_dly, input int stall,
                               input logic cnd, input logic [7:0] tgt,
                               input logic [7:0] cur_pc, input logic [7:0] exp_pc,
                               input logic [3:0] exp_mode, input logic halt_wait);
        check("fetch_rd_en", 32'(imem_rd_en), 32'(1'b1));
        check("fetch_addr",  32'(imem_addr),  32'(cur_pc));
        imem_valid = 1'b1;            // ignored outside WAIT
        imem_rdata = 8'hEE;
        step();
        imem_valid = 1'b0;
        check("wait_rd_en", 32'(imem_rd_en), 32'(1'b0));
        for (int i = 0; i < wait_dly; i++) begin
            step();
            check("wait_err", 32'(err),  32'(1'b0));
            check("wait_busy", 32'(busy), 32'(1'b1));
        end
        halt       = halt_wait;
        imem_valid = 1'b1;
        imem_rdata = data;
        step();
        halt       = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = ~data;
        check("decode_instr", 32'(instr), 32'(data));
        step();
        check("issue_valid", 32'(exec_valid), 32'(1'b1));
        check("issue_mode",  32'(mode),       32'(exp_mode));
        cond_true   = cnd;
        jump_target = tgt;
        exec_ready  = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", 32'(exec_valid), 32'(1'b1));
            check("stall_instr", 32'(instr),      32'(data));
            check("stall_mode",  32'(mode),       32'(exp_mode));
            check("stall_pc",    32'(pc),         32'(cur_pc));
        end
        exec_ready = 1'b1;
        step();
        check("hs_valid", 32'(exec_valid), 32'(1'b0));
        check("hs_pc",    32'(pc),         32'(exp_pc));
        check("hs_rd_en", 32'(imem_rd_en), 32'(!halt_wait));
        check("hs_busy",  32'(busy),       32'(!halt_wait));
        cond_true   = 1'b0;
        jump_target = 8'h5A;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        halt        = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 8'h00;
        exec_ready  = 1'b1;
        cond_true   = 1'b0;
        jump_target = 8'h00;
        step();
        step();
        check_reset_values("rst");

        // Sequential instruction, then conditional branch taken / not taken
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        issue_instr(8'h41, 0, 0, 1'b0, 8'h00, 8'h00, 8'h01, 4'b0010, 1'b0);
        issue_instr(8'hC0, 0, 0, 1'b1, 8'h20, 8'h01, 8'h20, 4'b1000, 1'b0);
        issue_instr(8'hC0, 0, 0, 1'b0, 8'h20, 8'h20, 8'h21, 4'b1000, 1'b0);
        // Backpressure for five cycles
        issue_instr(8'h85, 0, 5, 1'b0, 8'h00, 8'h21, 8'h22, 4'b0100, 1'b0);
        // Branch to the top of the address space, then wrap with a halt in WAIT
        issue_instr(8'hC3, 0, 0, 1'b1, 8'hFF, 8'h22, 8'hFF, 4'b1000, 1'b0);
        issue_instr(8'h02, 0, 0, 1'b0, 8'h00, 8'hFF, 8'h00, 4'b0001, 1'b1);
        repeat (3) step();
        check("idle_rd_en", 32'(imem_rd_en), 32'(1'b0));
        check("idle_busy",  32'(busy),       32'(1'b0));
        check("idle_instr", 32'(instr),      32'(8'h02));
        check("idle_mode",  32'(mode),       32'(4'b0001));

        // Valid arrives in the last allowed wait cycle
        start = 1'b1;
        step();
        start = 1'b0;
        issue_instr(8'h7E, 15, 0, 1'b0, 8'h00, 8'h00, 8'h01, 4'b0010, 1'b0);

        // Fetch timeout: no valid ever
        check("to_fetch", 32'(imem_rd_en), 32'(1'b1));
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_pre_err", 32'(err), 32'(1'b0));
        end
        step();
        check("to_err",  32'(err),  32'(1'b1));
        check("to_busy", 32'(busy), 32'(1'b0));
        start = 1'b1;
        repeat (4) begin
            step();
            check("err_no_fetch", 32'(imem_rd_en), 32'(1'b0));
            check("err_sticky",   32'(err),        32'(1'b1));
        end
        start = 1'b0;

        // Reset out of ERR, then reset in the middle of an issue
        rst_n = 1'b0;
        step();
        check_reset_values("rst_err");
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        issue_instr(8'h41, 0, 0, 1'b0, 8'h00, 8'h00, 8'h01, 4'b0010, 1'b0);
        step();
        imem_valid = 1'b1;
        imem_rdata = 8'hC5;
        step();
        imem_valid = 1'b0;
        exec_ready = 1'b0;
        step();
        check("mid_issue_valid", 32'(exec_valid), 32'(1'b1));
        check("mid_issue_mode",  32'(mode),       32'(4'b1000));
        rst_n = 1'b0;
        step();
        check_reset_values("rst_issue");
        rst_n      = 1'b1;
        exec_ready = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        issue_instr(8'h10, 0, 0, 1'b0, 8'h00, 8'h00, 8'h01, 4'b0001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
